// File: rtl/rr_onehot_arbiter_if.sv
// rr_onehot_arbiter_if: request/grant bundle between requesters and the round-robin arbiter.
interface rr_onehot_arbiter_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic       gnt_valid;
   logic       revoked;
   modport master (output req, input gnt, gnt_valid, revoked);
   modport slave  (input req, output gnt, gnt_valid, revoked);
endinterface

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: 8-way round-robin arbiter, registered one-hot grant with hold,
// release and timeout preemption; requester k owns bit [7-k] of req/gnt.
module rr_onehot_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input logic                clk,
   input logic                rst_n,
   rr_onehot_arbiter_if.slave bus
);
   typedef enum logic {IDLE, GRANT} state_t;
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   state_t           r_state, w_state_nxt;
   logic [7:0]       r_gnt, w_gnt_nxt;
   logic [2:0]       r_ptr, w_ptr_nxt;
   logic [2:0]       r_g, w_g_nxt;
   logic [CNT_W-1:0] r_hold, w_hold_nxt;
   logic             r_revoked, w_revoked_nxt;
   logic [7:0]       w_req_k;
   logic [2:0]       w_pick;
   logic             w_any, w_rel, w_tmo;
   // index requests by requester number rather than bit position
   for (genvar k = 0; k < 8; k++) begin : g_rev
      assign w_req_k[k] = bus.req[7-k];
   end
   assign w_any = |bus.req;
   assign w_rel = ~w_req_k[r_g];
   assign w_tmo = (MAX_HOLD != 0) && (r_hold == HOLD_LAST) && |(bus.req & ~r_gnt);
   // descending scan so the requester closest to ptr is assigned last and wins
   always_comb begin
      w_pick = r_ptr;
      for (int i = 7; i >= 0; i--)
         if (w_req_k[r_ptr + 3'(i)]) w_pick = r_ptr + 3'(i);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_ptr     <= '0;
         r_g       <= '0;
         r_hold    <= '0;
         r_revoked <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_ptr     <= w_ptr_nxt;
         r_g       <= w_g_nxt;
         r_hold    <= w_hold_nxt;
         r_revoked <= w_revoked_nxt;
      end
   end
   always_comb begin
      w_state_nxt = (r_state == IDLE) ? (w_any ? GRANT : IDLE)
                                      : ((w_rel || w_tmo) ? IDLE : GRANT);
   end
   // every grant exit goes through IDLE, giving the downstream encoder a zero bubble
   always_comb begin
      w_gnt_nxt     = '0;
      w_g_nxt       = r_g;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = '0;
      w_revoked_nxt = 1'b0;
      if (r_state == IDLE) begin
         if (w_any) begin
            w_gnt_nxt = 8'h80 >> w_pick;
            w_g_nxt   = w_pick;
         end
      end else if (w_rel || w_tmo) begin
         w_ptr_nxt     = r_g + 3'd1;
         w_revoked_nxt = ~w_rel;
      end else begin
         w_gnt_nxt  = r_gnt;
         w_hold_nxt = (r_hold == HOLD_LAST) ? r_hold : r_hold + CNT_W'(1);
      end
   end
   assign bus.gnt       = r_gnt;
   assign bus.gnt_valid = |r_gnt;
   assign bus.revoked   = r_revoked;
endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- 8-requester round-robin arbiter; produces a registered one-hot grant vector.
- Sits directly upstream of the team's 8-to-3 one-hot encoder, which converts the grant to a 3-bit requester index.
- Requester k (k = 0..7) is mapped to bit [7-k], so the encoder output equals k.
- Adds grant hold, release, and timeout preemption so the downstream encoder sees exactly one hot bit or all zeros.

Parameters:
- MAX_HOLD, 16: max consecutive GRANT cycles before forced revoke when another requester waits. 0 disables the timeout.
- CNT_W, 5: hold-counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request vector; bit [7-k] = requester k; level-sensitive
- gnt  output  8  registered grant, one-hot or 8'b0; bit [7-k] = requester k
- gnt_valid  output  1  high when gnt is non-zero
- revoked  output  1  one-cycle pulse on the cycle gnt drops due to timeout

Behaviour:
- Reset (async assert, sync deassert at clk edge): state=IDLE, gnt=8'b0, gnt_valid=0, revoked=0, ptr=0 (requester 0 highest priority), hold_cnt=0.
- Any rst_n low mid-grant clears all outputs immediately, independent of clk.
- Invariant: gnt is always 0 or exactly one bit set. gnt_valid == |gnt.
- State IDLE:
  - At a clk edge with req != 0: select the first requester with req set, searching k = ptr, ptr+1, ..., ptr+7 (mod 8).
  - gnt <= that one-hot bit, gnt_valid <= 1, hold_cnt <= 0, state <= GRANT.
  - Latency: req high at edge N gives gnt at edge N (visible after N).
  - req == 0: stay in IDLE, outputs 0.
- State GRANT (granted requester g), evaluated each clk edge in this priority order:
  1. Release: req bit of g == 0 -> gnt <= 0, gnt_valid <= 0, ptr <= (g+1) mod 8, state <= IDLE, revoked <= 0.
  2. Timeout: MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and any other req bit set -> gnt <= 0, gnt_valid <= 0, revoked <= 1, ptr <= (g+1) mod 8, state <= IDLE.
  3. Otherwise: hold gnt. hold_cnt <= hold_cnt+1, saturating at MAX_HOLD-1.
     - At saturation with no other requester, the grant continues indefinitely.
     - The timeout fires on the first edge another request appears.
- Always pass through IDLE for at least one cycle between grants: a one-cycle gnt=0 bubble, so the downstream encoder never sees two bits hot.
- Requests from requesters other than g that change during GRANT do not alter gnt.
- ptr wraps from 7 to 0.
- revoked is high for exactly one cycle, cleared on the next edge.

Test Plan:
- Reset/idle: rst_n=0 with req=8'hFF -> gnt=0, gnt_valid=0, revoked=0. Release reset with req=0 for 3 cycles -> outputs stay 0.
- Single request: req=8'b0000_1000 (requester 4) -> gnt=8'b0000_1000 after next edge, encoder out=3'b100. Drop req -> gnt=0 the following edge.
- Round-robin fairness: req=8'hFF held, each granted requester drops its bit for 1 cycle after 2 cycles of grant -> grant order k = 0,1,2,...,7,0 with a 1-cycle bubble between each grant.
- Wrap-around: after a grant to requester 7 (bit 0) is released, req=8'b1000_0001 -> requester 0 (gnt=8'b1000_0000) wins.
- Timeout: MAX_HOLD=4, requester 2 holds its req, requester 5 requests at cycle 1 -> gnt to requester 2 drops after its 4th cycle with revoked=1 for 1 cycle, then after the bubble gnt=8'b0000_0100. Separately, a lone requester held 20 cycles -> never revoked.
- Async reset mid-grant: assert rst_n=0 between clk edges while gnt=8'b0010_0000 -> gnt=0 immediately. After release, ptr=0 is confirmed by req=8'hFF granting requester 0.
